seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL have parameter NDIG, default 4, the number of multiplexed digits (>=2).
REQ-002 The block SHALL have parameter REFRESH_DIV, default 4, the clock cycles each digit is held (>=1).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1; 1 = anode/catode asserted low, 0 = asserted high.
REQ-004 The block SHALL have parameter LZ_SUPPRESS, default 0; 1 = leading-zero blanking enabled.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port reset, input, 1, a synchronous active-low reset (0 = reset).
REQ-007 The block SHALL have port en, input, 1, the scan enable.
REQ-008 The block SHALL have port load, input, 1, a one-cycle strobe that captures value/dp/blank.
REQ-009 The block SHALL have port value, input, 4*NDIG, one hex nibble per digit; nibble i drives digit i, with digit 0 least significant.
REQ-010 The block SHALL have ports dp and blank, input, NDIG each, giving per-digit decimal-point enable and force-blank.
REQ-011 The block SHALL have port anode, output, NDIG, the registered one-hot digit select.
REQ-012 The block SHALL have port catode, output, 8, registered segments: bit7=dp, bits6..0=g..a.
REQ-013 The block SHALL have port digit_idx, output, max(1,$clog2(NDIG)), the current scan index.
REQ-014 The block SHALL have port frame_done, output, 1, a registered one-cycle frame pulse.

Function
REQ-015 The prescaler SHALL count 0..REFRESH_DIV-1 while en=1, and wrap to 0.
REQ-016 On the cycle the prescaler equals REFRESH_DIV-1 (the tick), digit_idx SHALL advance, wrapping NDIG-1 -> 0.
REQ-017 A tick with digit_idx=NDIG-1 SHALL be a frame wrap, and frame_done SHALL be 1 in exactly the following cycle.
REQ-018 load=1 SHALL copy value/dp/blank into a pending register and set the pending flag; a later load overwrites pending.
REQ-019 On a frame wrap with pending set, the shadow register SHALL take the pending contents and the pending flag SHALL clear; the shadow never changes at any other time, so each frame is tear-free.
REQ-020 If load and a frame wrap occur in the same cycle, the newly loaded data SHALL go directly to shadow and the pending flag SHALL clear.
REQ-021 anode/catode SHALL be registered from digit_idx and shadow, with a latency of 1 cycle after a digit_idx change.
REQ-022 Hex patterns (active-high, bits g..a) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-023 The selected digit's anode SHALL be asserted and all others deasserted.
REQ-024 blank[i]=1 SHALL deassert all eight catode bits for digit i while its anode remains asserted.
REQ-025 With LZ_SUPPRESS=1, digit i>0 SHALL have segments a..g blanked when it and all more-significant nibbles are zero; digit 0 is never suppressed, and dp is still honoured.
REQ-026 With ACTIVE_LOW=1, anode and catode SHALL be the bitwise inverse of the active-high patterns.
REQ-027 With en=0, the prescaler and digit_idx SHALL hold, anode/catode SHALL go fully inactive the next cycle, frame_done SHALL be 0, and load SHALL still be captured.
REQ-028 With NDIG not a power of two, digit_idx SHALL still wrap at NDIG-1 and never reach NDIG.
REQ-029 With REFRESH_DIV=1, every enabled cycle SHALL be a tick.

Reset
REQ-030 When reset=0 at a clock edge, the block SHALL clear the prescaler, digit_idx, shadow, pending register and pending flag to 0.
REQ-031 When reset=0 at a clock edge, anode/catode SHALL go fully inactive: all-ones with ACTIVE_LOW=1.
REQ-032 When reset=0 at a clock edge, frame_done SHALL be 0.
REQ-033 reset SHALL override en and load in the same cycle.
REQ-034 A reset mid-frame SHALL restart scanning at digit 0 from the cycle after reset is released.

Verification
REQ-035 The bench SHALL hold reset=0 for 2 cycles and check: anode=4'b1111, catode=8'hFF, digit_idx=0, frame_done=0.
REQ-036 The bench SHALL load 16'h12AF with en=1 and, after the first wrap, check digit0 anode=1110/catode=8E, digit1 1101/88, digit2 1011/A4, digit3 0111/F9; each digit held 4 cycles, frame_done every 16 cycles.
REQ-037 The bench SHALL load 16'h0000 while digit_idx=1 and check that the digits keep 12AF patterns until the wrap, then all show C0.
REQ-038 The bench SHALL set dp[0]=1 and blank[2]=1 with 12AF and check digit0 catode=0E and digit2 catode=FF with anode=1011.
REQ-039 The bench SHALL load 16'h0050 with LZ_SUPPRESS=1 and check digits 3 and 2 = FF, digit1=92 and digit0=C0; then load 16'h0000 and check that only digit0 shows C0.
REQ-040 The bench SHALL drop en at digit_idx=2 and check that outputs are inactive next cycle and digit_idx holds; it SHALL re-enable and check that scanning resumes at digit 2; it SHALL pulse reset mid-frame and check a restart at digit 0.

Source files
------------

// File: rtl/seg7_scan.sv
// Multiplexed seven-segment scanner: per-digit hold prescaler, tear-free shadow
// register updated only at frame wrap, registered one-hot anode and segment outputs.
module seg7_scan #(
    parameter int NDIG        = 4,
    parameter int REFRESH_DIV = 4,
    parameter int ACTIVE_LOW  = 1,
    parameter int LZ_SUPPRESS = 0,
    localparam int IW = ($clog2(NDIG) < 1) ? 1 : $clog2(NDIG)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load,
    input  logic [4*NDIG-1:0] value,
    input  logic [NDIG-1:0]   dp,
    input  logic [NDIG-1:0]   blank,
    output logic [NDIG-1:0]   anode,
    output logic [7:0]        catode,
    output logic [IW-1:0]     digit_idx,
    output logic              frame_done
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic          AL     = (ACTIVE_LOW != 0);
    localparam logic [NDIG-1:0] AN_OFF = {NDIG{AL}};
    localparam logic [7:0]    CA_OFF = {8{AL}};
    localparam logic [NDIG-1:0] ONE_HOT0 = {{(NDIG-1){1'b0}}, 1'b1};

    logic [PW-1:0]     presc;
    logic [4*NDIG-1:0] pend_val, sh_val;
    logic [NDIG-1:0]   pend_dp, pend_blank, sh_dp, sh_blank;
    logic              pend_flag;

    logic              tick, wrap, lz;
    logic [3:0]        nib;
    logic [7:0]        seg_hi;
    logic [NDIG-1:0]   an_hi;

    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h6F;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h39;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    endfunction

    // Digit sel is a leading zero when it and every more-significant nibble are zero.
    function automatic logic lead_zero(input logic [4*NDIG-1:0] v, input int sel);
        logic nz;
        nz = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (i >= sel && v[4*i +: 4] != 4'h0) nz = 1'b1;
        end
        lead_zero = (LZ_SUPPRESS != 0) && (sel != 0) && !nz;
    endfunction

    assign tick = en && (presc == PW'(REFRESH_DIV - 1));
    assign wrap = tick && (digit_idx == IW'(NDIG - 1));

    always_comb begin
        nib    = sh_val[4*int'(digit_idx) +: 4];
        lz     = lead_zero(sh_val, int'(digit_idx));
        seg_hi = {sh_dp[digit_idx], lz ? 7'h00 : hex_seg(nib)};
        if (sh_blank[digit_idx]) seg_hi = 8'h00;
        an_hi  = ONE_HOT0 << digit_idx;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc      <= '0;
            digit_idx  <= '0;
            frame_done <= 1'b0;
            pend_val   <= '0;
            pend_dp    <= '0;
            pend_blank <= '0;
            pend_flag  <= 1'b0;
            sh_val     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '0;
            anode      <= AN_OFF;
            catode     <= CA_OFF;
        end else begin
            if (tick)    presc <= '0;
            else if (en) presc <= presc + 1'b1;

            if (tick) digit_idx <= (digit_idx == IW'(NDIG - 1)) ? '0 : digit_idx + 1'b1;

            frame_done <= wrap;

            // A load on the wrap cycle bypasses pending so it shows in the new frame.
            if (wrap && load) begin
                sh_val    <= value;
                sh_dp     <= dp;
                sh_blank  <= blank;
                pend_flag <= 1'b0;
            end else if (wrap && pend_flag) begin
                sh_val    <= pend_val;
                sh_dp     <= pend_dp;
                sh_blank  <= pend_blank;
                pend_flag <= 1'b0;
            end else if (load) begin
                pend_flag <= 1'b1;
            end

            if (load) begin
                pend_val   <= value;
                pend_dp    <= dp;
                pend_blank <= blank;
            end

            if (en) begin
                anode  <= an_hi ^ AN_OFF;
                catode <= seg_hi ^ CA_OFF;
            end else begin
                anode  <= AN_OFF;
                catode <= CA_OFF;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan: two instances sharing stimulus, one with
// leading-zero blanking, checked with immediate assertions.
module tb_seg7_scan;

    logic        clk = 1'b0;
    logic        reset, en, load;
    logic [15:0] value;
    logic [3:0]  dp, blank;
    logic [3:0]  anode, anode_lz;
    logic [7:0]  catode, catode_lz;
    logic [1:0]  digit_idx, digit_idx_lz;
    logic        frame_done, frame_done_lz;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seg7_scan #(.NDIG(4), .REFRESH_DIV(4), .ACTIVE_LOW(1), .LZ_SUPPRESS(0)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .value(value),
        .dp(dp), .blank(blank), .anode(anode), .catode(catode),
        .digit_idx(digit_idx), .frame_done(frame_done));

    seg7_scan #(.NDIG(4), .REFRESH_DIV(4), .ACTIVE_LOW(1), .LZ_SUPPRESS(1)) dut_lz (
        .clk(clk), .reset(reset), .en(en), .load(load), .value(value),
        .dp(dp), .blank(blank), .anode(anode_lz), .catode(catode_lz),
        .digit_idx(digit_idx_lz), .frame_done(frame_done_lz));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_fd();
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < 64) begin
            step(1);
            k++;
        end
        chk("wait_frame_done", {31'd0, frame_done}, 32'd1);
    endtask

    task automatic load_vec(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        value = v; dp = d; blank = b; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    // Called one cycle after a wrap; checks each digit then ends at the next wrap.
    task automatic frame_check(input string tag, input logic [7:0] c0, c1, c2, c3,
                               input logic [7:0] l0, l1, l2, l3);
        logic [7:0] ce [4];
        logic [7:0] le [4];
        ce[0] = c0; ce[1] = c1; ce[2] = c2; ce[3] = c3;
        le[0] = l0; le[1] = l1; le[2] = l2; le[3] = l3;
        step(1);
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("%s_anode%0d", tag, d), {28'd0, anode}, {28'd0, ~(4'b0001 << d)});
            chk($sformatf("%s_catode%0d", tag, d), {24'd0, catode}, {24'd0, ce[d]});
            chk($sformatf("%s_catode_lz%0d", tag, d), {24'd0, catode_lz}, {24'd0, le[d]});
            chk($sformatf("%s_idx%0d", tag, d), {30'd0, digit_idx}, d);
            if (d < 3) step(4);
        end
        step(2);
        chk({tag, "_fd_low"}, {31'd0, frame_done}, 32'd0);
        step(1);
        chk({tag, "_fd_high"}, {31'd0, frame_done}, 32'd1);
        chk({tag, "_fd_lz"}, {31'd0, frame_done_lz}, 32'd1);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; load = 1'b0;
        value = 16'h0; dp = 4'h0; blank = 4'h0;
        step(2);
        chk("rst_anode", {28'd0, anode}, 32'hF);
        chk("rst_catode", {24'd0, catode}, 32'hFF);
        chk("rst_idx", {30'd0, digit_idx}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);

        reset = 1'b1; en = 1'b1;
        load_vec(16'h12AF, 4'h0, 4'h0);
        chk("first_frame_digit0_zero", {24'd0, catode}, 32'hC0);
        wait_fd();
        frame_check("f12af", 8'h8E, 8'h88, 8'hA4, 8'hF9, 8'h8E, 8'h88, 8'hA4, 8'hF9);

        // Load zero while digit 1 is selected: current frame must stay intact.
        step(4);
        chk("midload_idx", {30'd0, digit_idx}, 32'd1);
        load_vec(16'h0000, 4'h0, 4'h0);
        chk("midload_d1", {24'd0, catode}, 32'h88);
        step(4);
        chk("midload_d2", {24'd0, catode}, 32'hA4);
        step(4);
        chk("midload_d3", {24'd0, catode}, 32'hF9);
        wait_fd();
        frame_check("f0000", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        load_vec(16'h12AF, 4'b0001, 4'b0100);
        wait_fd();
        frame_check("fdpblk", 8'h0E, 8'h88, 8'hFF, 8'hF9, 8'h0E, 8'h88, 8'hFF, 8'hF9);

        load_vec(16'h0050, 4'h0, 4'h0);
        wait_fd();
        frame_check("f0050", 8'hC0, 8'h92, 8'hC0, 8'hC0, 8'hC0, 8'h92, 8'hFF, 8'hFF);

        load_vec(16'h0000, 4'h0, 4'h0);
        wait_fd();
        frame_check("f0000b", 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hFF, 8'hFF, 8'hFF);

        // Enable drop at digit 2, resume, then reset mid-frame.
        step(8);
        chk("en_idx2", {30'd0, digit_idx}, 32'd2);
        en = 1'b0;
        step(1);
        chk("en_off_anode", {28'd0, anode}, 32'hF);
        chk("en_off_catode", {24'd0, catode}, 32'hFF);
        step(3);
        chk("en_off_idx_hold", {30'd0, digit_idx}, 32'd2);
        chk("en_off_fd", {31'd0, frame_done}, 32'd0);
        en = 1'b1;
        step(1);
        chk("resume_anode", {28'd0, anode}, 32'hB);
        chk("resume_idx", {30'd0, digit_idx}, 32'd2);
        reset = 1'b0;
        step(1);
        chk("midrst_anode", {28'd0, anode}, 32'hF);
        chk("midrst_idx", {30'd0, digit_idx}, 32'd0);
        chk("midrst_fd", {31'd0, frame_done}, 32'd0);
        reset = 1'b1;
        step(1);
        chk("restart_anode", {28'd0, anode}, 32'hE);
        chk("restart_catode", {24'd0, catode}, 32'hC0);
        step(3);
        chk("restart_idx1", {30'd0, digit_idx}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
